// File: rtl/noc_phase_sequencer.sv
// noc_phase_sequencer: steps the router mesh through Init, routing-table load and the
// LoadStaging/Phase0/Phase1 cycle. Optional early stop on all_done: `define EARLY_STOP_EN.
`default_nettype none

module noc_phase_sequencer #(
    parameter int ROUTERS = 16,
    parameter int DST_W   = 4,
    parameter int CYC_W   = 16,
    parameter int OP_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic [CYC_W-1:0] i_max_cycle,
    input  logic             i_rt_valid,
    input  logic             i_all_done,
    output logic [OP_W-1:0]  o_router_op,
    output logic [DST_W-1:0] o_rt_dst,
    output logic [CYC_W-1:0] o_in_cycle,
    output logic             o_busy,
`ifdef EARLY_STOP_EN
    output logic             o_stopped_early,
`endif
    output logic             o_finished
);

    // Router op encoding, shared with the router op definitions.
    localparam logic [OP_W-1:0] c_OP_NOP         = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_INIT        = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_LOAD_RT     = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_LOAD_STAGE  = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_PHASE0      = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_PHASE1      = OP_W'(5);
    localparam logic [DST_W-1:0] c_LAST_DST      = DST_W'(ROUTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_LOAD_RT = 3'd2,
        S_STAGE   = 3'd3,
        S_PH0     = 3'd4,
        S_PH1     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t           r_state;
    logic [OP_W-1:0]  r_op;
    logic [DST_W-1:0] r_rt_dst;
    logic [CYC_W-1:0] r_in_cycle;
    logic [CYC_W-1:0] r_max_cycle;
    logic             r_busy;
    logic             r_finished;
    logic [CYC_W-1:0] w_in_cycle_inc;
    logic             w_early;

    assign w_in_cycle_inc = r_in_cycle + CYC_W'(1);

`ifdef EARLY_STOP_EN
    logic r_stopped_early;
    assign w_early         = i_all_done;
    assign o_stopped_early = r_stopped_early;
`else
    logic w_unused_all_done;
    assign w_unused_all_done = i_all_done;
    assign w_early           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= c_OP_NOP;
            r_rt_dst    <= '0;
            r_in_cycle  <= '0;
            r_max_cycle <= '0;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
`ifdef EARLY_STOP_EN
            r_stopped_early <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_op <= c_OP_NOP;
                    if (i_start) begin
                        r_state     <= S_INIT;
                        r_op        <= c_OP_INIT;
                        r_max_cycle <= i_max_cycle;
                        r_busy      <= 1'b1;
                        r_finished  <= 1'b0;
                        r_in_cycle  <= '0;
                        r_rt_dst    <= '0;
`ifdef EARLY_STOP_EN
                        r_stopped_early <= 1'b0;
`endif
                    end
                end
                S_INIT: begin
                    r_state  <= S_LOAD_RT;
                    r_op     <= c_OP_LOAD_RT;
                    r_rt_dst <= '0;
                end
                S_LOAD_RT: begin
                    if (r_rt_dst != c_LAST_DST) begin
                        r_rt_dst <= r_rt_dst + DST_W'(1);
                    end else if (r_max_cycle == '0) begin
                        r_state    <= S_DONE;
                        r_op       <= c_OP_NOP;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end else begin
                        r_state <= S_STAGE;
                        r_op    <= i_pause ? c_OP_NOP : c_OP_LOAD_STAGE;
                    end
                end
                S_STAGE: begin
                    // A NOP op here marks a pause stall; LoadStaging is issued once pause drops.
                    if (r_op == c_OP_LOAD_STAGE) begin
                        r_state <= S_PH0;
                        r_op    <= c_OP_PHASE0;
                    end else if (!i_pause) begin
                        r_op <= c_OP_LOAD_STAGE;
                    end
                end
                S_PH0: begin
                    r_state <= S_PH1;
                    r_op    <= c_OP_PHASE1;
                end
                S_PH1: begin
                    r_in_cycle <= w_in_cycle_inc;
                    if (w_in_cycle_inc == r_max_cycle || w_early) begin
                        r_state    <= S_DONE;
                        r_op       <= c_OP_NOP;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
`ifdef EARLY_STOP_EN
                        r_stopped_early <= (w_in_cycle_inc != r_max_cycle);
`endif
                    end else begin
                        r_state <= S_STAGE;
                        r_op    <= i_pause ? c_OP_NOP : c_OP_LOAD_STAGE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_op    <= c_OP_NOP;
                end
            endcase
        end
    end

    // rt_valid is looked up from the current rt_dst, so it can only qualify LoadRt after the register.
    assign o_router_op = (r_op == c_OP_LOAD_RT && !i_rt_valid) ? c_OP_NOP : r_op;
    assign o_rt_dst    = r_rt_dst;
    assign o_in_cycle  = r_in_cycle;
    assign o_busy      = r_busy;
    assign o_finished  = r_finished;

endmodule

`default_nettype wire

// File: tb/tb_noc_phase_sequencer.sv
// tb_noc_phase_sequencer: directed cycle-by-cycle op sequences with hand-computed expectations.
`default_nettype none

module tb_noc_phase_sequencer;

    localparam int ROUTERS = 4;
    localparam int DST_W   = 2;
    localparam int CYC_W   = 16;
    localparam int OP_W    = 3;

    localparam logic [2:0] NOP = 3'd0, INI = 3'd1, LRT = 3'd2, LST = 3'd3, PH0 = 3'd4, PH1 = 3'd5;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic             i_pause;
    logic [CYC_W-1:0] i_max_cycle;
    logic             i_rt_valid;
    logic             i_all_done;
    logic [OP_W-1:0]  o_router_op;
    logic [DST_W-1:0] o_rt_dst;
    logic [CYC_W-1:0] o_in_cycle;
    logic             o_busy;
    logic             o_finished;
`ifdef EARLY_STOP_EN
    logic             o_stopped_early;
`endif

    logic sparse;
    assign i_rt_valid = sparse ? (o_rt_dst != 2'd2) : 1'b1;

    always #5 clk = ~clk;

    noc_phase_sequencer #(
        .ROUTERS(ROUTERS), .DST_W(DST_W), .CYC_W(CYC_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pause(i_pause),
        .i_max_cycle(i_max_cycle), .i_rt_valid(i_rt_valid), .i_all_done(i_all_done),
        .o_router_op(o_router_op), .o_rt_dst(o_rt_dst), .o_in_cycle(o_in_cycle),
        .o_busy(o_busy),
`ifdef EARLY_STOP_EN
        .o_stopped_early(o_stopped_early),
`endif
        .o_finished(o_finished)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    logic [2:0] eq[$];
    logic       pq[$];
    logic       aq[$];

    task automatic clr();
        eq.delete(); pq.delete(); aq.delete();
    endtask

    task automatic push(input logic [2:0] op, input logic p = 1'b0, input logic a = 1'b0);
        eq.push_back(op); pq.push_back(p); aq.push_back(a);
    endtask

    task automatic push_load(input logic skip2);
        push(INI);
        for (int i = 0; i < ROUTERS; i++) push((skip2 && i == 2) ? NOP : LRT);
    endtask

    task automatic push_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            push(LST); push(PH0); push(PH1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one queued sequence; edge k uses pq[k]/aq[k] and must produce eq[k].
    // start is pulsed on edge 0 and again on edge dup_start (ignored while busy).
    task automatic run(input string name, input int max, input int n_edges, input int dup_start);
        i_max_cycle = CYC_W'(max);
        for (int k = 0; k < n_edges; k++) begin
            i_start    = (k == 0 || k == dup_start);
            i_pause    = pq[k];
            i_all_done = aq[k];
            step();
            chk($sformatf("%s op[%0d]", name, k), o_router_op, eq[k]);
            if (k >= 1 && k <= ROUTERS)
                chk($sformatf("%s rt_dst[%0d]", name, k), o_rt_dst, k - 1);
            if (k == 0) begin
                chk({name, " busy_on_start"}, o_busy, 1);
                chk({name, " in_cycle_cleared"}, o_in_cycle, 0);
                chk({name, " finished_cleared"}, o_finished, 0);
            end
        end
        i_start = 1'b0; i_pause = 1'b0; i_all_done = 1'b0;
    endtask

    task automatic chk_done(input string name, input int cyc);
        chk({name, " finished"}, o_finished, 1);
        chk({name, " busy"}, o_busy, 0);
        chk({name, " in_cycle"}, o_in_cycle, cyc);
        chk({name, " rt_dst_hold"}, o_rt_dst, ROUTERS - 1);
        step();
        chk({name, " idle_op"}, o_router_op, NOP);
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_pause = 1'b0; i_max_cycle = '0;
        i_all_done = 1'b0; sparse = 1'b0;
        step(); step();
        chk("rst op", o_router_op, NOP);
        chk("rst rt_dst", o_rt_dst, 0);
        chk("rst in_cycle", o_in_cycle, 0);
        chk("rst busy", o_busy, 0);
        chk("rst finished", o_finished, 0);
        rst = 1'b0;
        step();
        chk("idle op", o_router_op, NOP);

        // Basic run: 1 + 4 + 3*2 = 11 op cycles, then DONE; a second start mid-run is ignored.
        clr(); push_load(1'b0); push_cycles(2); push(NOP);
        run("basic", 2, 12, 3);
        chk_done("basic", 2);

        // Sparse table, started from DONE: third LoadRt slot shows NOP.
        sparse = 1'b1;
        clr(); push_load(1'b1); push_cycles(2); push(NOP);
        run("sparse", 2, 12, -1);
        chk_done("sparse", 2);
        sparse = 1'b0;

        // Pause high on the edges entering the second STAGE and two more: 3 NOP stalls.
        // pause during PH0 (edge 13) changes nothing.
        clr(); push_load(1'b0); push_cycles(1);
        push(NOP, 1'b1); push(NOP, 1'b1); push(NOP, 1'b1);
        push(LST); push(PH0); push(PH1, 1'b1); push(NOP);
        run("pause", 2, 15, -1);
        chk_done("pause", 2);

        // Zero cycles: straight from routing-table load to DONE.
        clr(); push_load(1'b0); push(NOP);
        run("zero", 0, 6, -1);
        chk_done("zero", 0);

        // Reset mid-run: stop on second PH0 (in_cycle=1), then rst with start together.
        clr(); push_load(1'b0); push_cycles(2);
        run("rstmid", 2, 10, -1);
        chk("rstmid in_cycle_at_ph0", o_in_cycle, 1);
        rst = 1'b1; i_start = 1'b1;
        step();
        chk("rstmid op", o_router_op, NOP);
        chk("rstmid in_cycle", o_in_cycle, 0);
        chk("rstmid busy", o_busy, 0);
        chk("rstmid finished", o_finished, 0);
        rst = 1'b0; i_start = 1'b0;
        step();
        chk("rstmid still_idle op", o_router_op, NOP);
        chk("rstmid still_idle busy", o_busy, 0);

        // all_done during the third Phase1 (exit edge 14), max_cycle=10.
        clr(); push_load(1'b0); push_cycles(2);
        push(LST); push(PH0); push(PH1);
`ifdef EARLY_STOP_EN
        push(NOP, 1'b0, 1'b1);
        run("early", 10, 15, -1);
        chk("early stopped_early", o_stopped_early, 1);
        chk_done("early", 3);
`else
        push(LST, 1'b0, 1'b1); push(PH0); push(PH1);
        push_cycles(6); push(NOP);
        run("early", 10, 36, -1);
        chk_done("early", 10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
